// File: rtl/axis_arith_shift_sat_if.sv
// Stream bundle for axis_arith_shift_sat: input sample channel (s_*) and
// result channel (m_*). The slave modport is the scaler's view; the master
// modport is the view of whatever drives samples and consumes results.
interface axis_arith_shift_sat_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 23
);
  logic [IN_WIDTH-1:0]  s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [OUT_WIDTH-1:0] m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/axis_arith_shift_sat.sv
// Two-stage signed arithmetic shifter with round-half-up right shifts.
// Stage 1 shifts at full precision; stage 2 narrows to OUT_WIDTH.
// Build macro ASHIFT_SAT_EN: defined -> stage 2 saturates and ovf_sticky
// records saturation events; undefined -> stage 2 wraps and ovf_sticky is 0.
module axis_arith_shift_sat #(
  parameter int IN_WIDTH      = 32,
  parameter int OUT_WIDTH     = 23,
  parameter int SHIFT_W       = 6,
  parameter int MAX_SHIFT     = 16,
  parameter int DEFAULT_SHIFT = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axis_arith_shift_sat_if.slave bus,
  input  logic [SHIFT_W-1:0]   shift_in,
  input  logic                 shift_load,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  // Wide enough that a MAX_SHIFT left shift or the rounding add never overflows.
  localparam int ExtW = IN_WIDTH + MAX_SHIFT + 1;

  localparam logic signed [SHIFT_W-1:0] ShMax = SHIFT_W'(MAX_SHIFT);
  localparam logic signed [SHIFT_W-1:0] ShMin = -ShMax;

  logic                     w_en;
  logic signed [SHIFT_W-1:0] r_shift;
  logic signed [SHIFT_W-1:0] w_shift_clamped;
  logic [SHIFT_W-1:0]        w_mag;
  logic signed [ExtW-1:0]    w_x_ext;
  logic signed [ExtW-1:0]    w_round;
  logic signed [ExtW-1:0]    w_s1_next;
  logic                      r_s1_valid;
  logic signed [ExtW-1:0]    r_s1_data;
  logic [OUT_WIDTH-1:0]      w_s2_next;
  logic                      w_sat_event;
  logic                      r_m_valid;
  logic [OUT_WIDTH-1:0]      r_m_data;

  // Whole pipeline moves as one; it stalls only when the output is held.
  assign w_en               = !r_m_valid || bus.m_axis_tready;
  assign bus.s_axis_tready  = w_en;
  assign bus.m_axis_tvalid  = r_m_valid;
  assign bus.m_axis_tdata   = r_m_data;

  // Clamp the requested shift to +/-MAX_SHIFT before it is stored.
  always_comb begin
    w_shift_clamped = shift_in;
    if ($signed(shift_in) > ShMax) begin
      w_shift_clamped = ShMax;
    end else if ($signed(shift_in) < ShMin) begin
      w_shift_clamped = ShMin;
    end
  end

  // Shift-amount register; a load applies to samples accepted after this edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_shift <= SHIFT_W'(DEFAULT_SHIFT);
    end else if (shift_load) begin
      r_shift <= w_shift_clamped;
    end
  end

  // Stage-1 math: left shift, or round-half-up right shift by n = -shift.
  always_comb begin
    w_x_ext   = {{(ExtW-IN_WIDTH){bus.s_axis_tdata[IN_WIDTH-1]}}, bus.s_axis_tdata};
    w_mag     = r_shift[SHIFT_W-1] ? SHIFT_W'(-r_shift) : r_shift;
    w_round   = '0;
    w_s1_next = w_x_ext <<< w_mag;
    if (r_shift[SHIFT_W-1]) begin
      w_round   = {{(ExtW-1){1'b0}}, 1'b1} << (w_mag - SHIFT_W'(1));
      w_s1_next = (w_x_ext + w_round) >>> w_mag;
    end
  end

  // Stage-1 register; data only captured for real samples.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_en) begin
      r_s1_valid <= bus.s_axis_tvalid;
      if (bus.s_axis_tvalid) begin
        r_s1_data <= w_s1_next;
      end
    end
  end

`ifdef ASHIFT_SAT_EN
  localparam logic signed [ExtW-1:0] SatMax = ExtW'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ExtW-1:0] SatMin = ~SatMax;

  logic r_ovf;

  // Stage-2 narrowing with saturation to the signed OUT_WIDTH range.
  always_comb begin
    w_sat_event = 1'b0;
    w_s2_next   = r_s1_data[OUT_WIDTH-1:0];
    if (r_s1_data > SatMax) begin
      w_sat_event = 1'b1;
      w_s2_next   = SatMax[OUT_WIDTH-1:0];
    end else if (r_s1_data < SatMin) begin
      w_sat_event = 1'b1;
      w_s2_next   = SatMin[OUT_WIDTH-1:0];
    end
  end

  // Sticky overflow; a saturation in the same cycle as ovf_clr wins.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf <= 1'b0;
    end else if (w_en && r_s1_valid && w_sat_event) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovf;
`else
  logic w_unused;

  // Stage-2 narrowing by two's-complement wrap.
  always_comb begin
    w_sat_event = 1'b0;
    w_s2_next   = r_s1_data[OUT_WIDTH-1:0];
  end

  assign ovf_sticky = 1'b0;
  assign w_unused   = ^{ovf_clr, w_sat_event, r_s1_data[ExtW-1:OUT_WIDTH]};
`endif

  // Stage-2 (output) register; holds while downstream stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_en) begin
      r_m_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_m_data <= w_s2_next;
      end
    end
  end

endmodule

// File: tb/tb_axis_arith_shift_sat.sv
// Directed plus randomized bench for axis_arith_shift_sat. Expected results
// come from an integer model of the shift/round/narrow rules. SHIFT_W is
// widened to 7 so that an out-of-range load of -40 can be presented.
module tb_axis_arith_shift_sat;
  localparam int IN_WIDTH      = 32;
  localparam int OUT_WIDTH     = 23;
  localparam int SHIFT_W       = 7;
  localparam int MAX_SHIFT     = 16;
  localparam int DEFAULT_SHIFT = 8;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic [SHIFT_W-1:0] shift_in = '0;
  logic               shift_load = 1'b0;
  logic               ovf_clr = 1'b0;
  logic               ovf_sticky;

  axis_arith_shift_sat_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  axis_arith_shift_sat #(
    .IN_WIDTH     (IN_WIDTH),
    .OUT_WIDTH    (OUT_WIDTH),
    .SHIFT_W      (SHIFT_W),
    .MAX_SHIFT    (MAX_SHIFT),
    .DEFAULT_SHIFT(DEFAULT_SHIFT)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .shift_in  (shift_in),
    .shift_load(shift_load),
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  int model_shift = DEFAULT_SHIFT;
  logic signed [63:0] got_q[$];
  logic signed [63:0] exp_q[$];

  // Collect every result transferred downstream.
  always @(posedge aclk) begin
    if (aresetn && bus.m_axis_tvalid && bus.m_axis_tready) begin
      got_q.push_back(64'($signed(bus.m_axis_tdata)));
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_shift(input int s);
    if (s > MAX_SHIFT) return MAX_SHIFT;
    if (s < -MAX_SHIFT) return -MAX_SHIFT;
    return s;
  endfunction

  // Reference: exact scaled value, then saturate or wrap to OUT_WIDTH.
  function automatic void ref_result(input longint x, input int s,
                                     output longint y, output bit ovf);
    longint v, num, d, q, lim, span;
    if (s >= 0) begin
      v = x * (longint'(1) << s);
    end else begin
      d   = longint'(1) << (-s);
      num = x + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
      v = q;
    end
    lim  = longint'(1) << (OUT_WIDTH - 1);
    span = longint'(1) << OUT_WIDTH;
    ovf  = 1'b0;
`ifdef ASHIFT_SAT_EN
    if (v > lim - 1) begin
      y = lim - 1; ovf = 1'b1;
    end else if (v < -lim) begin
      y = -lim; ovf = 1'b1;
    end else begin
      y = v;
    end
`else
    y = v % span;
    if (y < 0) y = y + span;
    if (y >= lim) y = y - span;
`endif
  endfunction

  function automatic longint ref_y(input longint x, input int s);
    longint y;
    bit o;
    ref_result(x, s, y, o);
    return y;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic load_shift(input int v);
    shift_in   = SHIFT_W'(v);
    shift_load = 1'b1;
    tick();
    shift_load = 1'b0;
    model_shift = clamp_shift(v);
  endtask

  // Present one sample, wait (bounded) for acceptance, then check the result
  // one edge after the accept edge, with the pipeline initially empty.
  task automatic run_one(input string tag, input longint x);
    bit ok;
    longint y;
    bit o;
    ref_result(x, model_shift, y, o);
    bus.s_axis_tdata  = IN_WIDTH'(x);
    bus.s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = bus.s_axis_tready;
      tick();
    end
    bus.s_axis_tvalid = 1'b0;
    check({tag, "_accept"}, 64'(ok), 64'(1));
    check({tag, "_lat_valid0"}, 64'(bus.m_axis_tvalid), 64'(0));
    tick();
    check({tag, "_valid"}, 64'(bus.m_axis_tvalid), 64'(1));
    check({tag, "_data"}, 64'($signed(bus.m_axis_tdata)), y);
  endtask

  task automatic drain_compare(input string tag);
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("%s_item%0d", tag, k), got_q[k], exp_q[k]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    longint y;
    bit o;
    int i;
    int c;
    bit accepted;
    logic signed [IN_WIDTH-1:0] rx;

    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst_m_valid", 64'(bus.m_axis_tvalid), 64'(0));
    check("rst_m_data", 64'(bus.m_axis_tdata), 64'(0));
    check("rst_ovf", 64'(ovf_sticky), 64'(0));
    aresetn = 1'b1;
    tick();
    check("rst_s_ready", 64'(bus.s_axis_tready), 64'(1));

    // Default shift of 8.
    run_one("x1000", 1000);
    check("x1000_lit", 64'($signed(bus.m_axis_tdata)), 64'(256000));
    check("x1000_ovf", 64'(ovf_sticky), 64'(0));

    // Overflow on the positive side, then clear the sticky flag.
    ref_result(32767, model_shift, y, o);
    run_one("x32767", 32767);
    check("x32767_ovf", 64'(ovf_sticky), 64'(o));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 64'(ovf_sticky), 64'(0));

    // Rounding right shifts and clamped load.
    load_shift(-1);
    run_one("r5", 5);
    check("r5_lit", 64'($signed(bus.m_axis_tdata)), 64'(3));
    run_one("rm5", -5);
    check("rm5_lit", 64'($signed(bus.m_axis_tdata)), -64'sd2);
    load_shift(-40);
    run_one("r65536", 65536);
    check("r65536_lit", 64'($signed(bus.m_axis_tdata)), 64'(1));
    load_shift(40);
    run_one("clamp_pos", 3);
    check("clamp_pos_lit", 64'($signed(bus.m_axis_tdata)), 64'(196608));

    // Back-to-back 0..9 with a three-cycle downstream stall.
    load_shift(3);
    for (int k = 0; k < 4; k++) tick();
    got_q.delete();
    exp_q.delete();
    i = 0;
    c = 0;
    while (i < 10 && c < 100) begin
      bus.m_axis_tready = !(c >= 3 && c <= 5);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = IN_WIDTH'(i);
      #1;
      if (c >= 3 && c <= 5) check($sformatf("stall_ready_c%0d", c),
                                  64'(bus.s_axis_tready), 64'(0));
      if (bus.s_axis_tready) begin
        exp_q.push_back(ref_y(i, model_shift));
        i++;
      end
      @(posedge aclk);
      #1;
      c++;
    end
    check("stall_all_sent", 64'(i), 64'(10));
    drain_compare("stall");

    // Randomized traffic, shift reloads and back-pressure.
    for (c = 0; c < 400; c++) begin
      bus.m_axis_tready = ($urandom_range(0, 9) < 7);
      bus.s_axis_tvalid = ($urandom_range(0, 9) < 7);
      rx = $urandom;
      if ($urandom_range(0, 1) == 1) rx = rx >>> $urandom_range(0, 28);
      bus.s_axis_tdata = rx;
      shift_load = ($urandom_range(0, 9) == 0);
      shift_in   = SHIFT_W'($urandom_range(0, (1 << SHIFT_W) - 1));
      #1;
      accepted = bus.s_axis_tvalid && bus.s_axis_tready;
      if (accepted) exp_q.push_back(ref_y(longint'(rx), model_shift));
      if (shift_load) model_shift = clamp_shift(int'($signed(shift_in)));
      @(posedge aclk);
      #1;
    end
    shift_load = 1'b0;
    drain_compare("rand");

    // Reset with two samples in flight.
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = IN_WIDTH'(11);
    tick();
    bus.s_axis_tdata  = IN_WIDTH'(22);
    tick();
    bus.s_axis_tvalid = 1'b0;
    tick();
    check("inflight_valid", 64'(bus.m_axis_tvalid), 64'(1));
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.m_axis_tvalid), 64'(0));
    tick();
    tick();
    aresetn = 1'b1;
    model_shift = DEFAULT_SHIFT;
    bus.m_axis_tready = 1'b1;
    got_q.delete();
    exp_q.delete();
    tick();
    exp_q.push_back(ref_y(123, model_shift));
    run_one("postrst", 123);
    drain_compare("postrst");
    check("postrst_ovf", 64'(ovf_sticky), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
